siso_shift_controller: RTL and testbench

Sequencer and two-requester arbiter for a DATA_WIDTH-bit serial-in-serial-out shift register with shift enable. It accepts parallel words from two requesters under round-robin arbitration and serialises the granted word MSB-first into the register's serial input. At the same time it captures the word being pushed out of the register's serial output, which is the previously resident frame. A flush command retrieves the last resident frame by shifting in zeros.

---
 rtl/siso_shift_controller.sv | 179 +++++++++++++++++
 tb/tb_siso_shift_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_controller.sv
// Sequencer and two-requester round-robin arbiter for an external
// DATA_WIDTH-bit SISO shift register. Granted words are serialised MSB-first
// into the register while the previously resident frame is captured from the
// register's serial output. A flush shifts in zeros to retrieve the last frame.
module siso_shift_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Req0_Valid_In,
  input  logic [DATA_WIDTH-1:0] Req0_Data_In,
  output logic                  Req0_Ready_Out,
  input  logic                  Req1_Valid_In,
  input  logic [DATA_WIDTH-1:0] Req1_Data_In,
  output logic                  Req1_Ready_Out,
  input  logic                  Flush_In,
  output logic                  Shift_Enable_Out,
  output logic                  Serial_Data_Out,
  input  logic                  Serial_Return_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  Rx_Valid_Out,
  output logic [DATA_WIDTH-1:0] Rx_Data_Out,
  output logic                  Rx_Src_Out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [7:0] LAST_GAP = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [7:0]            gap_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  favour_req1;
  logic                  cur_is_flush;
  logic                  cur_src;
  logic                  resident;
  logic                  resident_src;
  logic                  shift_en;
  logic                  ser_bit;
  logic                  busy;
  logic                  done;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_src;

  logic                  is_idle;
  logic                  flush_go;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic [DATA_WIDTH-1:0] accept_data;
  logic [DATA_WIDTH-1:0] rx_next;

  // Arbitration: a pending flush (even an ignored one) masks both requesters;
  // otherwise the favoured requester wins if valid, else the other one.
  always_comb begin
    is_idle     = (state == ST_IDLE);
    flush_go    = is_idle && Flush_In && resident;
    grant0      = is_idle && !Flush_In && Req0_Valid_In && (!favour_req1 || !Req1_Valid_In);
    grant1      = is_idle && !Flush_In && Req1_Valid_In && (favour_req1 || !Req0_Valid_In);
    accept      = flush_go || grant0 || grant1;
    accept_data = '0;
    if (grant1) begin
      accept_data = Req1_Data_In;
    end else if (grant0) begin
      accept_data = Req0_Data_In;
    end
    rx_next     = {rx_sr[DATA_WIDTH-2:0], Serial_Return_In};
  end

  // Sequencer: IDLE accepts a word or flush, SHIFT drives DATA_WIDTH strobes
  // while capturing the returning frame, GAP pads idle cycles afterwards.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      favour_req1  <= 1'b0;
      cur_is_flush <= 1'b0;
      cur_src      <= 1'b0;
      resident     <= 1'b0;
      resident_src <= 1'b0;
      shift_en     <= 1'b0;
      ser_bit      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_src       <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // First bit is presented straight away; tx_sr keeps the remainder.
            tx_sr        <= {accept_data[DATA_WIDTH-2:0], 1'b0};
            ser_bit      <= accept_data[DATA_WIDTH-1];
            shift_en     <= 1'b1;
            busy         <= 1'b1;
            bit_cnt      <= '0;
            cur_is_flush <= flush_go;
            cur_src      <= grant1;
            if (!flush_go) begin
              favour_req1 <= grant0;
            end
            state        <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          rx_sr <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            shift_en <= 1'b0;
            ser_bit  <= 1'b0;
            done     <= 1'b1;
            // The resident flag is only updated here, so it still describes
            // the frame that was in the register when this operation began.
            if (resident) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_next;
              rx_src   <= resident_src;
            end
            resident <= !cur_is_flush;
            if (!cur_is_flush) begin
              resident_src <= cur_src;
            end
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end else begin
            ser_bit <= tx_sr[DATA_WIDTH-1];
            tx_sr   <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Req0_Ready_Out   = grant0;
  assign Req1_Ready_Out   = grant1;
  assign Shift_Enable_Out = shift_en;
  assign Serial_Data_Out  = ser_bit;
  assign Busy_Out         = busy;
  assign Done_Out         = done;
  assign Rx_Valid_Out     = rx_valid;
  assign Rx_Data_Out      = rx_data;
  assign Rx_Src_Out       = rx_src;

endmodule

// File: tb/tb_siso_shift_controller.sv
// Bench for siso_shift_controller: a timing-level reference model predicts
// grants and pushes expected frame results into a queue; a separate monitor
// pops and compares on every Done_Out. A second instance with no gap cycles
// checks back-to-back operation.
module tb_siso_shift_controller;

  localparam int W   = 16;
  localparam int GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A (GAP = 1) signals
  logic         rst, v0, v1, flush, r0, r1, se, sdo, ret, busy, done, rxv, rxs;
  logic [W-1:0] d0, d1, rxd, siso_a;

  // Instance B (GAP = 0) signals
  logic         rst_b, b_v0, b_v1, b_flush, b_r0, b_r1, b_se, b_sdo, b_ret;
  logic         b_busy, b_done, b_rxv, b_rxs;
  logic [W-1:0] b_d0, b_d1, b_rxd, siso_b;

  siso_shift_controller #(.DATA_WIDTH(W), .GAP_CYCLES(GAP)) u_dut (
    .Clk_In(clk), .Reset_In(rst),
    .Req0_Valid_In(v0), .Req0_Data_In(d0), .Req0_Ready_Out(r0),
    .Req1_Valid_In(v1), .Req1_Data_In(d1), .Req1_Ready_Out(r1),
    .Flush_In(flush), .Shift_Enable_Out(se), .Serial_Data_Out(sdo),
    .Serial_Return_In(ret), .Busy_Out(busy), .Done_Out(done),
    .Rx_Valid_Out(rxv), .Rx_Data_Out(rxd), .Rx_Src_Out(rxs)
  );

  siso_shift_controller #(.DATA_WIDTH(W), .GAP_CYCLES(0)) u_dut_nogap (
    .Clk_In(clk), .Reset_In(rst_b),
    .Req0_Valid_In(b_v0), .Req0_Data_In(b_d0), .Req0_Ready_Out(b_r0),
    .Req1_Valid_In(b_v1), .Req1_Data_In(b_d1), .Req1_Ready_Out(b_r1),
    .Flush_In(b_flush), .Shift_Enable_Out(b_se), .Serial_Data_Out(b_sdo),
    .Serial_Return_In(b_ret), .Busy_Out(b_busy), .Done_Out(b_done),
    .Rx_Valid_Out(b_rxv), .Rx_Data_Out(b_rxd), .Rx_Src_Out(b_rxs)
  );

  // External SISO registers sharing each controller's reset
  always @(posedge clk) begin
    if (rst) siso_a <= '0;
    else if (se) siso_a <= {siso_a[W-2:0], sdo};
    if (rst_b) siso_b <= '0;
    else if (b_se) siso_b <= {siso_b[W-2:0], b_sdo};
  end
  assign ret   = siso_a[W-1];
  assign b_ret = siso_b[W-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (instance A) ----------------
  typedef struct {
    int           done_cyc;
    bit           rxv;
    logic [W-1:0] rxd;
    bit           rxs;
    logic [W-1:0] tx;
  } exp_t;

  exp_t         exp_q[$];
  bit           m_res, m_src, m_fav1;
  logic [W-1:0] m_word;
  int           m_free;

  always @(negedge clk) begin
    bit   idle, fl, g0, g1;
    exp_t e;
    if (rst) begin
      m_res  = 1'b0;
      m_fav1 = 1'b0;
      m_free = cyc + 1;
      exp_q.delete();
    end else begin
      idle = (cyc >= m_free);
      fl   = idle && flush && m_res;
      g0   = idle && !flush && v0 && (!m_fav1 || !v1);
      g1   = idle && !flush && v1 && (m_fav1 || !v0);
      chk("busy", busy, !idle);
      chk("ready0", r0, g0);
      chk("ready1", r1, g1);
      if (fl || g0 || g1) begin
        e.done_cyc = cyc + W + 1;
        e.rxv      = m_res;
        e.rxd      = m_word;
        e.rxs      = m_src;
        e.tx       = fl ? '0 : (g1 ? d1 : d0);
        exp_q.push_back(e);
        if (fl) begin
          m_res = 1'b0;
        end else begin
          m_res  = 1'b1;
          m_word = e.tx;
          m_src  = g1;
          m_fav1 = !g1;
        end
        m_free = cyc + W + 1 + GAP;
      end
    end
  end

  // ---------------- monitor (instance A) ----------------
  logic [W-1:0] mon_acc;
  int           mon_n;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_acc = '0;
      mon_n   = 0;
    end else begin
      if (se) begin
        mon_acc = {mon_acc[W-2:0], sdo};
        mon_n++;
      end else begin
        chk("serial_low_when_idle", sdo, 1'b0);
      end
      chk("rx_valid_only_with_done", rxv & ~done, 1'b0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("shift_count", mon_n, W);
          chk("serial_word", mon_acc, e.tx);
          chk("rx_valid", rxv, e.rxv);
          if (e.rxv) begin
            chk("rx_data", rxd, e.rxd);
            chk("rx_src", rxs, e.rxs);
          end
        end
        mon_n = 0;
      end else if (exp_q.size() > 0 && exp_q[0].done_cyc <= cyc) begin
        chk("done_missing", done, 1'b1);
        e = exp_q.pop_front();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit src, input logic [W-1:0] data);
    bit got = 1'b0;
    if (src) begin v1 = 1'b1; d1 = data; end
    else     begin v0 = 1'b1; d0 = data; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = src ? r1 : r0;
      step();
    end
    if (src) v1 = 1'b0; else v0 = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = !busy;
    end
    if (!seen) chk("idle_timeout", 0, 1);
    step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_se"}, se, 0);
    chk({tag, "_sdo"}, sdo, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rxv"}, rxv, 0);
    chk({tag, "_rxd"}, rxd, 0);
    chk({tag, "_rxs"}, rxs, 0);
    chk({tag, "_r0"}, r0, 0);
    chk({tag, "_r1"}, r1, 0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit             last, a0, a1;
    int             n, dn, bn;
    logic [2*W-1:0] b_bits;

    rst = 1'b1; v0 = 0; v1 = 0; flush = 0; d0 = '0; d1 = '0;
    rst_b = 1'b1; b_v0 = 0; b_v1 = 0; b_flush = 0; b_d0 = '0; b_d1 = '0;
    repeat (3) step();
    rst = 1'b0;
    check_zero("reset");

    // Single frame, nothing resident yet
    send(1'b0, 16'hA5C3);
    wait_idle();
    // Second frame returns the first
    send(1'b1, 16'h1234);
    wait_idle();

    // Both requesters continuously valid: grants must alternate
    v0 = 1'b1; v1 = 1'b1; d0 = W'($urandom); d1 = W'($urandom);
    n = 0; last = 1'b0;
    for (int g = 0; g < 1000 && n < 8; g++) begin
      @(negedge clk);
      a0 = r0; a1 = r1;
      if (a0 || a1) begin
        if (n > 0) chk("grant_alternates", a1, !last);
        last = a1;
        n++;
      end
      step();
      if (a0) d0 = W'($urandom);
      if (a1) d1 = W'($urandom);
    end
    chk("alternate_grants_seen", n, 8);
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // Frame then flush, then an ignored flush
    send(1'b1, 16'hBEEF);
    wait_idle();
    do_flush();
    wait_idle();
    do_flush();
    repeat (W + 4) step();

    // Reset during the 8th shift cycle
    send(1'b0, W'($urandom));
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("midshift_reset");
    send(1'b1, 16'h0F0F);
    wait_idle();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      v0    = ($urandom % 10) < 6;
      v1    = ($urandom % 10) < 6;
      flush = ($urandom % 16) == 0;
      d0    = W'($urandom);
      d1    = W'($urandom);
      step();
    end
    v0 = 0; v1 = 0; flush = 0;
    repeat (W + GAP + 6) step();
    chk("queue_drained", exp_q.size(), 0);

    // No-gap instance: back-to-back frames
    rst_b = 1'b0;
    b_v0 = 1'b1; b_d0 = 16'h1357;
    b_v1 = 1'b1; b_d1 = 16'h2468;
    @(negedge clk);
    chk("b_grant0_first", b_r0, 1);
    chk("b_ready1_first", b_r1, 0);
    step();
    b_v0 = 1'b0;
    dn = 0; bn = 0; b_bits = '0;
    for (int i = 0; i < 80 && dn < 2; i++) begin
      @(negedge clk);
      if (b_se) begin
        b_bits = {b_bits[2*W-2:0], b_sdo};
        bn++;
      end
      a1 = b_r1;
      if (b_done) begin
        dn++;
        if (dn == 1) begin
          chk("b_done1_with_ready1", b_r1, 1);
          chk("b_shifts_frame1", bn, W);
          chk("b_rxv_frame1", b_rxv, 0);
        end else begin
          chk("b_shifts_total", bn, 2 * W);
          chk("b_serial_bits", b_bits, {16'h1357, 16'h2468});
          chk("b_rxv_frame2", b_rxv, 1);
          chk("b_rxd_frame2", b_rxd, 16'h1357);
          chk("b_rxs_frame2", b_rxs, 0);
        end
      end
      if (dn == 1 && !b_done) chk("b_shift_resumes", b_se, 1);
      step();
      if (a1) b_v1 = 1'b0;
    end
    chk("b_done_count", dn, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
